// File: rtl/aibcr3_dcc_pkg.sv
// Shared definitions for the DCC helper-clock block.
//   meas_state_e : measurement FSM states (IDLE/ALIGN/COUNT/DONE)
//   DEF_WIN_LEN  : default measurement window length in clk cycles
//   DEF_ARM_CNT  : default launch rises needed before a channel arms
//   ch_sel_w()   : channel-select width for a given channel count
package aibcr3_dcc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meas_state_e;

  localparam int DEF_WIN_LEN = 512;
  localparam int DEF_ARM_CNT = 4;

  // A single channel still needs a one-bit select.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/aibcr3_dcc_helper_ch.sv
// One helper-clock channel: strobe edge detect, arm counter, helper
// toggle flop and the bypass output mux.
//   clk, rst        : block clock, async active-high reset
//   launch, measure : level strobes; their rising edges drive the toggle
//   dcc_byp,clk_dcd : bypass select and bypass clock
//   ckout           : dcc_byp ? clk_dcd : tog
//   tog             : helper clock (used by the shared measurement FSM)
//   ch_armed        : set once ARM_CNT launch rises have been seen
module aibcr3_dcc_helper_ch
  import aibcr3_dcc_pkg::*;
#(
  parameter int ARM_CNT = DEF_ARM_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  input  logic measure,
  input  logic dcc_byp,
  input  logic clk_dcd,
  output logic ckout,
  output logic tog,
  output logic ch_armed
);

  localparam int ARM_W = $clog2(ARM_CNT + 1);

  logic             launch_r;
  logic             measure_r;
  logic [ARM_W-1:0] arm_cnt_r;
  logic             armed_r;
  logic             tog_r;
  logic             launch_rise_s;
  logic             measure_rise_s;
  logic             tog_nxt_s;

  assign launch_rise_s  = launch & ~launch_r;
  assign measure_rise_s = measure & ~measure_r;

  // Next helper level; only the edge matching the current level can act,
  // so a simultaneous launch+measure rise never double-toggles.
  always_comb begin
    tog_nxt_s = tog_r;
    if (!armed_r) begin
      tog_nxt_s = 1'b0;
    end else if (!tog_r && launch_rise_s) begin
      tog_nxt_s = 1'b1;
    end else if (tog_r && measure_rise_s) begin
      tog_nxt_s = 1'b0;
    end else begin
      tog_nxt_s = tog_r;
    end
  end

  // Strobe history, saturating arm counter, armed flag and helper flop.
  // armed_r is read before its update, so the arming rise cannot set tog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch_r  <= 1'b0;
      measure_r <= 1'b0;
      arm_cnt_r <= {ARM_W{1'b0}};
      armed_r   <= 1'b0;
      tog_r     <= 1'b0;
    end else begin
      launch_r  <= launch;
      measure_r <= measure;
      if (launch_rise_s && (arm_cnt_r != ARM_W'(ARM_CNT))) begin
        arm_cnt_r <= arm_cnt_r + ARM_W'(1);
      end
      if (launch_rise_s && (arm_cnt_r == ARM_W'(ARM_CNT - 1))) begin
        armed_r <= 1'b1;
      end
      tog_r <= tog_nxt_s;
    end
  end

  assign ckout    = dcc_byp ? clk_dcd : tog_r;
  assign tog      = tog_r;
  assign ch_armed = armed_r;

endmodule

// File: rtl/aibcr3_dcc_helper_mc.sv
// Multi-channel DCC helper-clock generator with duty measurement.
//   clk, rst           : block clock, async active-high reset
//   launch, measure    : per-channel strobes (level, clk-synchronous)
//   dcc_byp, clk_dcd   : per-channel bypass select / bypass clock
//   ckout, ch_armed    : per-channel output clock and armed flag
//   meas_start,meas_ch : start request and channel to measure
//   meas_busy          : measurement in progress (ALIGN/COUNT/DONE)
//   meas_done          : one-cycle result strobe
//   meas_hi_cnt        : helper-high cycles over the WIN_LEN window
//   meas_err           : bad/unarmed channel or alignment timeout
module aibcr3_dcc_helper_mc
  import aibcr3_dcc_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ARM_CNT = DEF_ARM_CNT,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = 10,
  parameter int CH_W    = ch_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] launch,
  input  logic [NUM_CH-1:0] measure,
  input  logic [NUM_CH-1:0] dcc_byp,
  input  logic [NUM_CH-1:0] clk_dcd,
  output logic [NUM_CH-1:0] ckout,
  output logic [NUM_CH-1:0] ch_armed,
  input  logic              meas_start,
  input  logic [CH_W-1:0]   meas_ch,
  output logic              meas_busy,
  output logic              meas_done,
  output logic [CNT_W-1:0]  meas_hi_cnt,
  output logic              meas_err
);

  localparam int SEL_N = 2 ** CH_W;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

  logic [NUM_CH-1:0] tog_s;
  logic [SEL_N-1:0]  tog_pad_s;
  logic [SEL_N-1:0]  armed_pad_s;
  meas_state_e       state_r;
  meas_state_e       state_nxt_s;
  logic [CH_W-1:0]   sel_r;
  logic [CNT_W-1:0]  win_cnt_r;
  logic [CNT_W-1:0]  hi_acc_r;
  logic [CNT_W-1:0]  hi_nxt_s;
  logic              tog_prev_r;
  logic              sel_tog_s;
  logic              start_ok_s;
  logic              align_hit_s;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    aibcr3_dcc_helper_ch #(.ARM_CNT(ARM_CNT)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .launch   (launch[gi]),
      .measure  (measure[gi]),
      .dcc_byp  (dcc_byp[gi]),
      .clk_dcd  (clk_dcd[gi]),
      .ckout    (ckout[gi]),
      .tog      (tog_s[gi]),
      .ch_armed (ch_armed[gi])
    );
  end

  // Widen per-channel vectors to the full select range; selects beyond
  // NUM_CH read as unarmed, which folds the range check into the arm check.
  always_comb begin
    tog_pad_s   = {SEL_N{1'b0}};
    armed_pad_s = {SEL_N{1'b0}};
    tog_pad_s[NUM_CH-1:0]   = tog_s;
    armed_pad_s[NUM_CH-1:0] = ch_armed;
  end

  assign sel_tog_s   = tog_pad_s[sel_r];
  assign start_ok_s  = armed_pad_s[meas_ch];
  assign align_hit_s = sel_tog_s & ~tog_prev_r;
  assign hi_nxt_s    = hi_acc_r + {{(CNT_W-1){1'b0}}, sel_tog_s};

  // Measurement FSM next-state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (meas_start) begin
          state_nxt_s = start_ok_s ? ST_ALIGN : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (align_hit_s) begin
          state_nxt_s = ST_COUNT;
        end else if (win_cnt_r == WIN_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
      ST_COUNT: begin
        if (win_cnt_r == WIN_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, window/high counters and registered result outputs.
  // win_cnt_r doubles as the ALIGN timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= {CH_W{1'b0}};
      win_cnt_r   <= {CNT_W{1'b0}};
      hi_acc_r    <= {CNT_W{1'b0}};
      tog_prev_r  <= 1'b0;
      meas_busy   <= 1'b0;
      meas_done   <= 1'b0;
      meas_hi_cnt <= {CNT_W{1'b0}};
      meas_err    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      meas_busy <= (state_nxt_s != ST_IDLE);
      meas_done <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (meas_start) begin
            sel_r      <= meas_ch;
            tog_prev_r <= tog_pad_s[meas_ch];
            win_cnt_r  <= {CNT_W{1'b0}};
            hi_acc_r   <= {CNT_W{1'b0}};
            if (!start_ok_s) begin
              meas_hi_cnt <= {CNT_W{1'b0}};
              meas_err    <= 1'b1;
            end
          end
        end
        ST_ALIGN: begin
          tog_prev_r <= sel_tog_s;
          if (align_hit_s) begin
            win_cnt_r <= {CNT_W{1'b0}};
            hi_acc_r  <= {CNT_W{1'b0}};
          end else if (win_cnt_r == WIN_LAST) begin
            meas_hi_cnt <= {CNT_W{1'b0}};
            meas_err    <= 1'b1;
          end else begin
            win_cnt_r <= win_cnt_r + CNT_W'(1);
          end
        end
        ST_COUNT: begin
          win_cnt_r <= win_cnt_r + CNT_W'(1);
          hi_acc_r  <= hi_nxt_s;
          if (win_cnt_r == WIN_LAST) begin
            meas_hi_cnt <= hi_nxt_s;
            meas_err    <= 1'b0;
          end
        end
        ST_DONE: begin
          tog_prev_r <= tog_prev_r;
        end
        default: begin
          tog_prev_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aibcr3_dcc_helper_mc.sv
// Self-checking bench: a cycle-level behavioural model (strobe rises,
// arm counts, helper levels, measurement outcome by edge arithmetic) is
// advanced at every rising edge; one process compares all outputs on the
// falling edge. Directed literal checks pin the model's key numbers.
module tb_aibcr3_dcc_helper_mc;
  localparam int NUM_CH  = 5;
  localparam int ARM_CNT = 4;
  localparam int WIN_LEN = 512;
  localparam int CNT_W   = 10;
  localparam int CH_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_CH-1:0] launch = '0, measure = '0, dcc_byp = '0, clk_dcd = '0;
  logic [NUM_CH-1:0] ckout, ch_armed;
  logic meas_start = 1'b0;
  logic [CH_W-1:0] meas_ch = '0;
  logic meas_busy, meas_done, meas_err;
  logic [CNT_W-1:0] meas_hi_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aibcr3_dcc_helper_mc #(.NUM_CH(NUM_CH), .ARM_CNT(ARM_CNT), .WIN_LEN(WIN_LEN),
                         .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .launch(launch), .measure(measure),
    .dcc_byp(dcc_byp), .clk_dcd(clk_dcd), .ckout(ckout), .ch_armed(ch_armed),
    .meas_start(meas_start), .meas_ch(meas_ch), .meas_busy(meas_busy),
    .meas_done(meas_done), .meas_hi_cnt(meas_hi_cnt), .meas_err(meas_err)
  );

  // ---------------- behavioural model ----------------
  int m_cnt[NUM_CH];
  bit m_armed[NUM_CH], m_tog[NUM_CH], m_lprev[NUM_CH], m_mprev[NUM_CH];
  bit m_pend, m_aligned, m_done, m_err, m_prev;
  int m_ch, m_start_e, m_align_e, m_hi, m_hi_out, e;

  // stimulus modes: 0 idle, 1 random, 2 periodic (period 8), 3 manual
  int mode[NUM_CH];
  int hi_len[NUM_CH];
  int ph = 0;
  bit rand_byp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_armed[i] = 0; m_tog[i] = 0; m_lprev[i] = 0; m_mprev[i] = 0;
    end
    m_pend = 0; m_aligned = 0; m_done = 0; m_err = 0; m_prev = 0;
    m_ch = 0; m_hi = 0; m_hi_out = 0;
  endtask

  task automatic model_edge();
    bit tpre[NUM_CH];
    bit apre[NUM_CH];
    bit lr, mr, done_prev, ok, t;
    e++;
    for (int i = 0; i < NUM_CH; i++) begin
      tpre[i] = m_tog[i];
      apre[i] = m_armed[i];
      lr = launch[i] && !m_lprev[i];
      mr = measure[i] && !m_mprev[i];
      m_lprev[i] = launch[i];
      m_mprev[i] = measure[i];
      if (lr && m_cnt[i] < ARM_CNT) m_cnt[i]++;
      m_armed[i] = (m_cnt[i] == ARM_CNT);
      if (!apre[i]) m_tog[i] = 0;
      else if (!m_tog[i] && lr) m_tog[i] = 1;
      else if (m_tog[i] && mr) m_tog[i] = 0;
    end
    done_prev = m_done;
    m_done = 0;
    if (!m_pend && !done_prev) begin
      if (meas_start) begin
        ok = 0;
        if (int'(meas_ch) < NUM_CH) ok = apre[meas_ch];
        if (!ok) begin
          m_done = 1; m_err = 1; m_hi_out = 0;
        end else begin
          m_pend = 1; m_ch = meas_ch; m_start_e = e; m_aligned = 0; m_prev = tpre[meas_ch];
        end
      end
    end else if (m_pend) begin
      t = tpre[m_ch];
      if (!m_aligned) begin
        if (t && !m_prev) begin
          m_aligned = 1; m_align_e = e; m_hi = 0;
        end else if (e - m_start_e == WIN_LEN) begin
          m_pend = 0; m_done = 1; m_err = 1; m_hi_out = 0;
        end
      end else begin
        m_hi += int'(t);
        if (e - m_align_e == WIN_LEN) begin
          m_pend = 0; m_done = 1; m_err = 0; m_hi_out = m_hi;
        end
      end
      m_prev = t;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [NUM_CH-1:0] exp_ck, exp_arm;
    if (chk_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        exp_ck[i]  = dcc_byp[i] ? clk_dcd[i] : m_tog[i];
        exp_arm[i] = m_armed[i];
      end
      check("ckout", 32'(ckout), 32'(exp_ck));
      check("ch_armed", 32'(ch_armed), 32'(exp_arm));
      check("meas_busy", 32'(meas_busy), 32'(m_pend || m_done));
      check("meas_done", 32'(meas_done), 32'(m_done));
      check("meas_hi_cnt", 32'(meas_hi_cnt), 32'(m_hi_out));
      check("meas_err", 32'(meas_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic gen_inputs();
    ph++;
    for (int i = 0; i < NUM_CH; i++) begin
      case (mode[i])
        0: begin launch[i] = 1'b0; measure[i] = 1'b0; end
        1: begin
          launch[i]  = ($urandom_range(0, 2) == 0);
          measure[i] = ($urandom_range(0, 2) == 0);
        end
        2: begin
          launch[i]  = (ph % 8 == 0);
          measure[i] = (ph % 8 == hi_len[i]);
        end
        default: ;
      endcase
      clk_dcd[i] = 1'($urandom_range(0, 1));
    end
    if (rand_byp) dcc_byp = NUM_CH'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #2;
    meas_start = 1'b0;
    gen_inputs();
  endtask

  task automatic pulse(input int ch, input bit l, input bit m);
    launch[ch] = l; measure[ch] = m;
    step();
    launch[ch] = 1'b0; measure[ch] = 1'b0;
  endtask

  task automatic run_meas(input int ch, input int exp_hi, input bit exp_err,
                          input int exp_lat, input string nm);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    meas_ch = CH_W'(ch);
    meas_start = 1'b1;
    step();
    for (int i = 0; i < 3 * WIN_LEN; i++) begin
      if (meas_done) begin
        seen = 1;
        break;
      end
      step();
      lat++;
    end
    if (!seen) begin
      check({nm, "_timeout"}, 32'(seen), 32'd1);
    end else begin
      check({nm, "_hi"}, 32'(meas_hi_cnt), 32'(exp_hi));
      check({nm, "_err"}, 32'(meas_err), 32'(exp_err));
      if (exp_lat >= 0) check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      step();
      check({nm, "_single"}, 32'(meas_done), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin mode[i] = 3; hi_len[i] = 3; end
    mode[2] = 2; hi_len[2] = 3;
    mode[3] = 2; hi_len[3] = 5;
    model_reset();
    e = 0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();
    check("rst_busy", 32'(meas_busy), 32'd0);
    check("rst_armed", 32'(ch_armed), 32'd0);
    check("rst_ckout", 32'(ckout), 32'd0);
    check("rst_hi", 32'(meas_hi_cnt), 32'd0);
    rst = 1'b0;

    // arming on ch0: three rises leave it unarmed, the fourth arms it
    for (int k = 0; k < 3; k++) begin pulse(0, 1, 0); step(); end
    check("arm3", 32'(ch_armed[0]), 32'd0);
    pulse(0, 1, 0);
    check("arm4", 32'(ch_armed[0]), 32'd1);
    check("arm4_tog", 32'(ckout[0]), 32'd0);
    step();

    // toggle on ch1
    for (int k = 0; k < 4; k++) begin pulse(1, 1, 0); step(); end
    pulse(1, 1, 0);
    check("tog_set", 32'(ckout[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("tog_hold", 32'(ckout[1]), 32'd1);
    end
    pulse(1, 0, 1);
    check("tog_clr", 32'(ckout[1]), 32'd0);
    step();
    pulse(1, 1, 0);
    step();
    pulse(1, 1, 1);
    check("tog_simul", 32'(ckout[1]), 32'd0);
    step();
    check("tog_simul2", 32'(ckout[1]), 32'd0);

    // duty measurement on ch2 (period 8, high 3)
    repeat (60) step();
    run_meas(2, 192, 1'b0, -1, "duty2");

    // bad channel: error one cycle after start
    run_meas(5, 0, 1'b1, 0, "badch");

    // armed ch4 with no strobes: alignment timeout
    for (int k = 0; k < 4; k++) begin pulse(4, 1, 0); step(); end
    mode[4] = 0;
    run_meas(4, 0, 1'b1, WIN_LEN, "tmo");

    // bypass on ch3 does not disturb the tog-based measurement
    dcc_byp[3] = 1'b1;
    run_meas(3, 320, 1'b0, -1, "byp3");
    dcc_byp[3] = 1'b0;

    // reset 100 cycles into COUNT
    meas_ch = CH_W'(2);
    meas_start = 1'b1;
    step();
    for (int i = 0; i < 3 * WIN_LEN; i++) begin
      if (m_pend && m_aligned && (e - m_align_e == 100)) break;
      step();
    end
    check("midrst_reached", 32'(m_pend && m_aligned), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", 32'(meas_busy), 32'd0);
    check("midrst_armed", 32'(ch_armed), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (60) step();
    run_meas(2, 192, 1'b0, -1, "rearm2");

    // randomized traffic on all channels with random measurement requests
    for (int i = 0; i < NUM_CH; i++) mode[i] = 1;
    rand_byp = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      meas_start = ($urandom_range(0, 39) == 0);
      meas_ch = CH_W'($urandom_range(0, 7));
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aibcr3_dcc_helper_mc.md
Name: aibcr3_dcc_helper_mc

Overview:
Multi-channel, parametrised DCC helper-clock generator with built-in duty measurement.
- Each channel arms after a programmable number of launch events.
- Once armed, each channel builds a helper clock that sets on launch and clears on measure, with a per-channel bypass to clk_dcd.
- A shared measurement FSM counts helper-high cycles of one selected channel over a fixed window, for DCC calibration firmware.
- Sits between the per-lane DCD/DLL launch/measure strobes and the DCC calibration controller.

Parameters:
NUM_CH, 4, number of helper channels (>=1)
ARM_CNT, 4, rising launch events required before a channel arms (>=1)
WIN_LEN, 512, measurement window length in clk cycles (>=2)
CNT_W, 10, counter width; must satisfy 2**CNT_W > WIN_LEN
CH_W, 2, channel select width = max(1, clog2(NUM_CH))

Ports:
clk  in  1  block clock; all strobes sampled on rising edge
rst  in  1  asynchronous active-high reset
launch  in  NUM_CH  per-channel launch strobe (level, synchronous to clk)
measure  in  NUM_CH  per-channel measure strobe (level, synchronous to clk)
dcc_byp  in  NUM_CH  per-channel bypass select
clk_dcd  in  NUM_CH  per-channel bypass clock
ckout  out  NUM_CH  per-channel output = dcc_byp ? clk_dcd : tog
ch_armed  out  NUM_CH  channel armed flag
meas_start  in  1  single-cycle request to start a measurement
meas_ch  in  CH_W  channel to measure, sampled with meas_start
meas_busy  out  1  FSM not IDLE
meas_done  out  1  one-cycle pulse; result valid
meas_hi_cnt  out  CNT_W  helper-high cycle count over the window
meas_err  out  1  valid with meas_done: bad channel or timeout

Behaviour:
- Reset (async, rst=1): all registers clear.
  - tog=0, ch_armed=0, arm counters=0.
  - FSM=IDLE, meas_busy=0, meas_done=0, meas_hi_cnt=0, meas_err=0.
  - ckout follows dcc_byp ? clk_dcd : 0.
- Edge detect: launch and measure are registered once; rise = cur & ~prev.
  - Rise visible the cycle after the level goes high.
- Arming, per channel:
  - Counter increments on each launch rise, saturating at ARM_CNT.
  - ch_armed=1 in the cycle after the ARM_CNT-th rise.
  - Cleared only by rst.
- Toggle, per channel, effective the cycle after the rise:
  - Not armed: tog held 0.
  - Armed, tog=0, launch rise -> tog=1.
  - Armed, tog=1, measure rise -> tog=0.
  - Simultaneous launch and measure rise: only the edge matching the current state acts. There is no double toggle.
  - The launch rise that completes arming does not itself set tog.
- ckout: combinational mux. dcc_byp changes take effect immediately. tog keeps running while bypassed.
- Measurement FSM, states IDLE, ALIGN, COUNT, DONE:
  - IDLE: on meas_start, latch meas_ch.
    - If meas_ch >= NUM_CH or the channel is not armed -> DONE with err=1, hi_cnt=0.
    - Else -> ALIGN.
    - meas_start is ignored in any state other than IDLE.
  - ALIGN: wait for a 0->1 transition of the selected tog (registered), then -> COUNT with window counter=0 and hi counter=0.
    - Timeout: if no transition within WIN_LEN cycles -> DONE with err=1, hi_cnt=0.
  - COUNT: each cycle, window counter +1; hi counter +1 if selected tog=1.
    - After exactly WIN_LEN counted cycles -> DONE.
    - meas_hi_cnt ranges 0..WIN_LEN; no overflow given the CNT_W constraint.
  - DONE: one cycle. meas_done=1; meas_hi_cnt and meas_err updated.
    - Then -> IDLE. meas_hi_cnt and meas_err hold until the next DONE.
  - meas_busy=1 in ALIGN, COUNT and DONE.
- Measurement samples tog, never clk_dcd; dcc_byp has no effect on the measurement.
- rst asserted mid-measurement: immediate return to IDLE; no meas_done is issued.

Decomposition:
- Shared package aibcr3_dcc_pkg holds:
  - the FSM state enum (IDLE/ALIGN/COUNT/DONE),
  - the CH_W derivation function,
  - the default WIN_LEN/ARM_CNT constants.
- One sub-module, aibcr3_dcc_helper_ch, generated NUM_CH times. It contains the edge detect, arm counter, tog flop and ckout mux.
- The measurement FSM and counters live in the top level.

Test Plan:
- Reset arming: rst, then 3 launch rises on ch0 with ARM_CNT=4 -> ch_armed[0]=0, tog=0. The 4th rise -> ch_armed[0]=1 next cycle and tog stays 0.
- Toggle: armed ch1, launch rise at cycle 10, measure rise at cycle 14 -> tog high for cycles 11-14, low from cycle 15. Simultaneous launch+measure rise while tog=1 -> tog goes 0 only.
- Duty measure: ch2 launch/measure period 8, high 3 cycles, WIN_LEN=512 -> meas_done once, meas_hi_cnt=192, meas_err=0, meas_busy high throughout.
- Error paths: meas_ch=5 with NUM_CH=4 -> meas_done 1 cycle after start, err=1, hi_cnt=0. An armed channel with no strobes -> timeout after 512 ALIGN cycles, err=1.
- Bypass: dcc_byp[3]=1 -> ckout[3] tracks clk_dcd[3] exactly while measurement on ch3 still reports the tog duty.
- Reset mid-COUNT: assert rst at window cycle 100 -> meas_busy=0 and ch_armed=0 immediately. No meas_done pulse is produced, and a new meas_start after re-arming completes normally.
